// File: rtl/amo_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | amo_sequencer_pkg : shared types and constants for the RV64A sequencer     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package amo_sequencer_pkg;

    localparam int AMO_XLEN     = 64;
    localparam int AMO_RESV_LSB = 3;

    localparam logic [2:0] LW_SW = 3'b010;
    localparam logic [2:0] LD_SD = 3'b011;

    typedef enum logic [4:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_LR   = 5'b00010,
        AMO_SC   = 5'b00011,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } funct5_amo_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } amo_state_t;

    typedef struct packed {
        logic                             valid;
        logic [AMO_XLEN-AMO_RESV_LSB-1:0] granule;
    } amo_resv_t;

    function automatic logic funct5_legal(input logic [4:0] f);
        case (f)
            AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/amo_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | amo_alu : combinational read-modify-write operator for AMO* instructions   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module amo_alu
    import amo_sequencer_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [4:0]      funct5_i,
    input  logic            is_word_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] new_o
);

    // Word ops: sign-extend for signed compare, zero-extend for unsigned compare,
    // so a single XLEN-wide comparator serves both widths.
    logic [XLEN-1:0] w_a_s, w_b_s, w_a_u, w_b_u, w_res;
    logic            w_lt_s, w_lt_u;

    assign w_a_s  = is_word_i ? {{(XLEN-32){old_i[31]}}, old_i[31:0]} : old_i;
    assign w_b_s  = is_word_i ? {{(XLEN-32){rs2_i[31]}}, rs2_i[31:0]} : rs2_i;
    assign w_a_u  = is_word_i ? {{(XLEN-32){1'b0}}, old_i[31:0]} : old_i;
    assign w_b_u  = is_word_i ? {{(XLEN-32){1'b0}}, rs2_i[31:0]} : rs2_i;
    assign w_lt_s = $signed(w_a_s) < $signed(w_b_s);
    assign w_lt_u = w_a_u < w_b_u;

    always_comb begin
        w_res = w_b_s;
        case (funct5_i)
            AMO_ADD:  w_res = w_a_s + w_b_s;
            AMO_XOR:  w_res = w_a_s ^ w_b_s;
            AMO_OR:   w_res = w_a_s | w_b_s;
            AMO_AND:  w_res = w_a_s & w_b_s;
            AMO_MIN:  w_res = w_lt_s ? w_a_s : w_b_s;
            AMO_MAX:  w_res = w_lt_s ? w_b_s : w_a_s;
            AMO_MINU: w_res = w_lt_u ? w_a_u : w_b_u;
            AMO_MAXU: w_res = w_lt_u ? w_b_u : w_a_u;
            default:  w_res = w_b_s;
        endcase
    end

    assign new_o = is_word_i ? {{(XLEN-32){1'b0}}, w_res[31:0]} : w_res;

endmodule
`default_nettype wire

// File: rtl/amo_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | amo_sequencer : LR/SC/AMO read-modify-write sequencer with reservation     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module amo_sequencer
    import amo_sequencer_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int RESV_LSB = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [4:0]      req_funct5_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_data_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_data_o,
    output logic            resp_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic            mem_dword_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i,
    input  logic            snoop_st_i,
    input  logic [XLEN-1:0] snoop_addr_i,
    input  logic            flush_i
);

    amo_state_t      state_q, state_d;
    amo_resv_t       resv_q, resv_d, w_resv_cand;
    logic [4:0]      funct5_q, funct5_d;
    logic            is_word_q, is_word_d;
    logic [XLEN-1:0] rs2_q, rs2_d, rd_q, rd_d;
    logic            err_q, err_d;
    logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d, mem_dword_q, mem_dword_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

    logic                     w_req_word, w_req_bad, w_sc_ok, w_resv_set, w_resv_clr;
    logic [XLEN-RESV_LSB-1:0] w_req_gran, w_snoop_gran, w_mem_gran;
    logic [XLEN-1:0]          w_alu_new, w_rd_ext;
    logic                     unused_snoop_lsb;

    assign unused_snoop_lsb = ^snoop_addr_i[RESV_LSB-1:0];

    assign w_req_word   = (req_funct3_i == LW_SW);
    assign w_req_bad    = !((req_funct3_i == LW_SW) || (req_funct3_i == LD_SD))
                        || !funct5_legal(req_funct5_i)
                        || (w_req_word ? (req_addr_i[1:0] != 2'b00) : (req_addr_i[2:0] != 3'b000));
    assign w_req_gran   = req_addr_i[XLEN-1:RESV_LSB];
    assign w_snoop_gran = snoop_addr_i[XLEN-1:RESV_LSB];
    assign w_mem_gran   = mem_addr_q[XLEN-1:RESV_LSB];
    // A same-cycle conflicting store or flush must already defeat the SC.
    assign w_sc_ok      = resv_q.valid && (resv_q.granule == w_req_gran) && !flush_i
                        && !(snoop_st_i && (w_snoop_gran == w_req_gran));
    assign w_rd_ext     = is_word_q ? {{(XLEN-32){mem_rdata_i[31]}}, mem_rdata_i[31:0]} : mem_rdata_i;

    amo_alu #(.XLEN(XLEN)) u_alu (
        .funct5_i  (funct5_q),
        .is_word_i (is_word_q),
        .old_i     (mem_rdata_i),
        .rs2_i     (rs2_q),
        .new_o     (w_alu_new)
    );

    always_comb begin
        state_d     = state_q;
        funct5_d    = funct5_q;
        is_word_d   = is_word_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        err_d       = err_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_dword_d = mem_dword_q;
        w_resv_set  = 1'b0;
        w_resv_clr  = 1'b0;
        case (state_q)
            IDLE: if (req_valid_i) begin
                funct5_d    = req_funct5_i;
                is_word_d   = w_req_word;
                rs2_d       = req_data_i;
                mem_addr_d  = req_addr_i;
                mem_dword_d = !w_req_word;
                err_d       = 1'b0;
                rd_d        = '0;
                if (w_req_bad) begin
                    err_d      = 1'b1;
                    w_resv_clr = 1'b1;
                    state_d    = RESP;
                end else if (req_funct5_i == AMO_SC) begin
                    w_resv_clr = 1'b1;
                    if (w_sc_ok) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = w_req_word ? {{(XLEN-32){1'b0}}, req_data_i[31:0]} : req_data_i;
                        state_d     = WRITE;
                    end else begin
                        rd_d    = {{(XLEN-1){1'b0}}, 1'b1};
                        state_d = RESP;
                    end
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b0;
                    state_d   = READ;
                end
            end
            READ: if (mem_ack_i) begin
                if (mem_err_i) begin
                    err_d      = 1'b1;
                    rd_d       = '0;
                    mem_req_d  = 1'b0;
                    w_resv_clr = 1'b1;
                    state_d    = RESP;
                end else begin
                    rd_d = w_rd_ext;
                    if (funct5_q == AMO_LR) begin
                        mem_req_d  = 1'b0;
                        w_resv_set = 1'b1;
                        state_d    = RESP;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = w_alu_new;
                        state_d     = WRITE;
                    end
                end
            end
            WRITE: if (mem_ack_i) begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                state_d   = RESP;
                if (mem_err_i) begin
                    err_d      = 1'b1;
                    rd_d       = '0;
                    w_resv_clr = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Clears are applied after a set so a coinciding snoop/flush wins over LR.
    always_comb begin
        w_resv_cand = w_resv_set ? {1'b1, w_mem_gran} : resv_q;
        resv_d      = w_resv_cand;
        if (w_resv_clr || flush_i || (snoop_st_i && (w_snoop_gran == w_resv_cand.granule))) begin
            resv_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            resv_q      <= '0;
            funct5_q    <= '0;
            is_word_q   <= 1'b0;
            rs2_q       <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_dword_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            resv_q      <= resv_d;
            funct5_q    <= funct5_d;
            is_word_q   <= is_word_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_dword_q <= mem_dword_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_data_o  = resp_valid_o ? rd_q : '0;
    assign resp_err_o   = resp_valid_o && err_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_dword_o  = mem_dword_q;

endmodule
`default_nettype wire

// File: tb/tb_amo_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_amo_sequencer : directed + randomized bench with a memory/reservation   |
// | model. Revision: 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_amo_sequencer;
    import amo_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [4:0]  req_funct5_i = '0;
    logic [2:0]  req_funct3_i = '0;
    logic [63:0] req_addr_i = '0;
    logic [63:0] req_data_i = '0;
    logic        resp_valid_o;
    logic [63:0] resp_data_o;
    logic        resp_err_o;
    logic        mem_req_o, mem_we_o, mem_dword_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;
    logic        snoop_st_i = 1'b0;
    logic [63:0] snoop_addr_i = '0;
    logic        flush_i = 1'b0;

    amo_sequencer #(.XLEN(64), .RESV_LSB(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_funct5_i(req_funct5_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_dword_o(mem_dword_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .snoop_st_i(snoop_st_i), .snoop_addr_i(snoop_addr_i), .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mem [logic [63:0]];
    bit          m_rv = 1'b0;
    logic [60:0] m_rg = '0;
    logic [63:0] obs_rd, obs_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_get(input logic [63:0] idx);
        if (!mem.exists(idx)) mem[idx] = {$urandom, $urandom};
        return mem[idx];
    endfunction

    function automatic bit legal5(input logic [4:0] f);
        return f inside {5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08, 5'h0C,
                         5'h10, 5'h14, 5'h18, 5'h1C};
    endfunction

    // Reference operator: plain signed/unsigned integer arithmetic per width.
    function automatic logic [63:0] amo_f(input logic [4:0] f, input bit w,
                                          input logic [63:0] o, input logic [63:0] b);
        int              sa, sb, r;
        int unsigned     ua, ub;
        longint          la, lb, lr;
        longint unsigned qa, qb;
        sa = o[31:0]; sb = b[31:0]; ua = o[31:0]; ub = b[31:0];
        la = o; lb = b; qa = o; qb = b;
        r = sb; lr = lb;
        case (f)
            5'h00: begin r = sa + sb; lr = la + lb; end
            5'h04: begin r = sa ^ sb; lr = la ^ lb; end
            5'h08: begin r = sa | sb; lr = la | lb; end
            5'h0C: begin r = sa & sb; lr = la & lb; end
            5'h10: begin r = (sa < sb) ? sa : sb; lr = (la < lb) ? la : lb; end
            5'h14: begin r = (sa > sb) ? sa : sb; lr = (la > lb) ? la : lb; end
            5'h18: begin r = (ua < ub) ? ua : ub; lr = (qa < qb) ? qa : qb; end
            5'h1C: begin r = (ua > ub) ? ua : ub; lr = (qa > qb) ? qa : qb; end
            default: ;
        endcase
        return w ? {32'h0, r} : lr;
    endfunction

    task automatic idle_ev(input bit snp, input logic [63:0] sa, input bit fl);
        @(negedge clk);
        snoop_st_i = snp; snoop_addr_i = sa; flush_i = fl;
        if (fl) m_rv = 1'b0;
        if (snp && (sa[63:3] == {3'b0, m_rg})) m_rv = 1'b0;
        @(negedge clk);
        snoop_st_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic do_op(input logic [4:0] f5, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] data, input int rdly, input int wdly,
                         input bit erd, input bit ewr, input bit snp);
        bit          w, bad, sc_ok, exp_err;
        logic [63:0] idx, dw, old, rdv, nv, wexp, exp_rd;
        logic [31:0] wd;
        int          exp_cyc, exp_nr, exp_nw, cyc, nr, nw, ctr;
        w   = (f3 == 3'b010);
        bad = !(f3 == 3'b010 || f3 == 3'b011) || !legal5(f5)
            || (w ? (addr[1:0] != 2'b00) : (addr[2:0] != 3'b000));
        idx = addr >> 3;
        exp_err = 1'b0; exp_rd = '0; exp_nr = 0; exp_nw = 0; exp_cyc = 1;
        wexp = '0; rdv = '0;
        dw  = mem_get(idx);
        wd  = addr[2] ? dw[63:32] : dw[31:0];
        old = w ? {{32{wd[31]}}, wd} : dw;
        if (bad) begin
            exp_err = 1'b1; m_rv = 1'b0;
        end else if (f5 == 5'h03) begin
            sc_ok = m_rv && (m_rg == idx[60:0]);
            m_rv  = 1'b0;
            if (sc_ok) begin
                exp_nw = 1; exp_cyc = 2 + wdly;
                wexp = w ? {32'h0, data[31:0]} : data;
                exp_err = ewr;
            end else begin
                exp_rd = 64'd1;
            end
        end else begin
            exp_nr = 1;
            rdv = w ? {$urandom, wd} : dw;
            if (erd) begin
                exp_err = 1'b1; exp_cyc = 2 + rdly; m_rv = 1'b0;
            end else if (f5 == 5'h02) begin
                exp_rd = old; exp_cyc = 2 + rdly;
                m_rv = !snp; m_rg = idx[60:0];
            end else begin
                if (snp && m_rv && (m_rg == idx[60:0])) m_rv = 1'b0;
                nv = amo_f(f5, w, old, data);
                wexp = w ? {32'h0, nv[31:0]} : nv;
                exp_nw = 1; exp_cyc = 3 + rdly + wdly;
                if (ewr) begin exp_err = 1'b1; m_rv = 1'b0; end
                else exp_rd = old;
            end
        end
        if (exp_nw == 1 && !ewr) begin
            if (!w) dw = wexp;
            else if (addr[2]) dw[63:32] = wexp[31:0];
            else dw[31:0] = wexp[31:0];
            mem[idx] = dw;
        end

        @(negedge clk);
        chk("req_ready", 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1; req_funct5_i = f5; req_funct3_i = f3;
        req_addr_i = addr; req_data_i = data;
        cyc = 0; nr = 0; nw = 0; ctr = 0; obs_wdata = '0;
        while (1) begin
            @(negedge clk);
            req_valid_i = 1'b0; mem_ack_i = 1'b0; mem_err_i = 1'b0; snoop_st_i = 1'b0;
            cyc++;
            if (resp_valid_o) break;
            if (cyc > 40) begin
                chk("timeout_cycles", 64'(cyc), 64'(exp_cyc));
                break;
            end
            if (mem_req_o) begin
                if (ctr == (mem_we_o ? wdly : rdly)) begin
                    if (!mem_we_o) begin
                        chk("rd_addr", mem_addr_o, addr);
                        chk("rd_dword", 64'(mem_dword_o), 64'(!w));
                        mem_rdata_i = rdv; mem_err_i = erd;
                        snoop_st_i = snp; snoop_addr_i = addr;
                        nr++;
                    end else begin
                        chk("wr_addr", mem_addr_o, addr);
                        chk("wr_data", mem_wdata_o, wexp);
                        chk("wr_dword", 64'(mem_dword_o), 64'(!w));
                        obs_wdata = mem_wdata_o;
                        mem_rdata_i = {$urandom, $urandom}; mem_err_i = ewr;
                        nw++;
                    end
                    mem_ack_i = 1'b1; ctr = 0;
                end else begin
                    ctr++;
                end
            end
        end
        obs_rd = resp_data_o;
        chk("resp_data", resp_data_o, exp_rd);
        chk("resp_err", 64'(resp_err_o), 64'(exp_err));
        chk("latency", 64'(cyc), 64'(exp_cyc));
        chk("n_reads", 64'(nr), 64'(exp_nr));
        chk("n_writes", 64'(nw), 64'(exp_nw));
        chk("req_dropped", 64'(mem_req_o), 64'd0);
    endtask

    initial begin
        logic [4:0]  ops [12];
        logic [4:0]  f5;
        logic [2:0]  f3;
        logic [63:0] a, t;
        ops = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C, 5'h02};

        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(req_ready_o), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_resp_err", 64'(resp_err_o), 64'd0);
        chk("rst_resp_data", resp_data_o, 64'd0);
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_mem_we", 64'(mem_we_o), 64'd0);
        chk("rst_mem_addr", mem_addr_o, 64'd0);
        rst_n = 1'b1;

        // LR/SC pair succeeds
        mem[64'h1000 >> 3] = 64'h5;
        do_op(AMO_LR, LD_SD, 64'h1000, 64'h0, 0, 0, 0, 0, 0);
        chk("lr_d_rd", obs_rd, 64'h5);
        do_op(AMO_SC, LD_SD, 64'h1000, 64'h9, 0, 0, 0, 0, 0);
        chk("sc_d_wdata", obs_wdata, 64'h9);
        chk("sc_d_rd", obs_rd, 64'h0);

        // reservation killed by same-granule snoop, then by flush
        do_op(AMO_LR, LW_SW, 64'h2000, 64'h0, 0, 0, 0, 0, 0);
        idle_ev(1'b1, 64'h2004, 1'b0);
        do_op(AMO_SC, LW_SW, 64'h2000, 64'h77, 0, 0, 0, 0, 0);
        chk("sc_snoop_rd", obs_rd, 64'h1);
        do_op(AMO_LR, LW_SW, 64'h2000, 64'h0, 0, 0, 0, 0, 0);
        idle_ev(1'b0, 64'h0, 1'b1);
        do_op(AMO_SC, LW_SW, 64'h2000, 64'h77, 0, 0, 0, 0, 0);
        chk("sc_flush_rd", obs_rd, 64'h1);

        // word arithmetic and compare rules
        mem[64'h3000 >> 3] = 64'hDEADBEEF_7FFFFFFF;
        do_op(AMO_ADD, LW_SW, 64'h3000, 64'h1, 0, 0, 0, 0, 0);
        chk("addw_wdata", obs_wdata, 64'h0000_0000_8000_0000);
        chk("addw_rd", obs_rd, 64'h0000_0000_7FFF_FFFF);
        mem[64'h3000 >> 3] = 64'h0_FFFFFFFF;
        do_op(AMO_MAX, LW_SW, 64'h3000, 64'h1, 0, 0, 0, 0, 0);
        chk("maxw_wdata", obs_wdata, 64'h1);
        chk("maxw_rd", obs_rd, 64'hFFFF_FFFF_FFFF_FFFF);
        mem[64'h3000 >> 3] = 64'h0_FFFFFFFF;
        do_op(AMO_MAXU, LW_SW, 64'h3000, 64'h1, 0, 0, 0, 0, 0);
        chk("maxuw_wdata", obs_wdata, 64'h0000_0000_FFFF_FFFF);

        // errors at accept
        do_op(AMO_SWAP, LD_SD, 64'h3004, 64'h1, 0, 0, 0, 0, 0);
        do_op(5'h1F, LD_SD, 64'h3000, 64'h1, 0, 0, 0, 0, 0);
        do_op(AMO_ADD, 3'b000, 64'h3000, 64'h1, 0, 0, 0, 0, 0);

        // bus error on read clears reservation
        do_op(AMO_LR, LD_SD, 64'h1008, 64'h0, 0, 0, 0, 0, 0);
        do_op(AMO_OR, LD_SD, 64'h1008, 64'hF0, 0, 0, 1, 0, 0);
        do_op(AMO_SC, LD_SD, 64'h1008, 64'h1, 0, 0, 0, 0, 0);
        chk("sc_after_err_rd", obs_rd, 64'h1);

        // delayed acks; snoop coinciding with the LR ack
        do_op(AMO_ADD, LD_SD, 64'h6000, 64'h5, 3, 3, 0, 0, 0);
        do_op(AMO_LR, LD_SD, 64'h7000, 64'h0, 1, 0, 0, 0, 1);
        do_op(AMO_SC, LD_SD, 64'h7000, 64'h2, 0, 0, 0, 0, 0);
        chk("sc_lr_snoop_rd", obs_rd, 64'h1);

        // reset in the middle of WRITE
        @(negedge clk);
        req_valid_i = 1'b1; req_funct5_i = AMO_OR; req_funct3_i = LD_SD;
        req_addr_i = 64'h5000; req_data_i = 64'h3;
        @(negedge clk);
        req_valid_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 64'h10;
        @(negedge clk);
        mem_ack_i = 1'b0;
        chk("rst_mid_we_pre", 64'(mem_we_o), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_req", 64'(mem_req_o), 64'd0);
        chk("rst_mid_we", 64'(mem_we_o), 64'd0);
        chk("rst_mid_ready", 64'(req_ready_o), 64'd1);
        chk("rst_mid_resp", 64'(resp_valid_o), 64'd0);
        rst_n = 1'b1; m_rv = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_resp", 64'(resp_valid_o), 64'd0);

        // randomized traffic over four granules
        for (int i = 0; i < 80; i++) begin
            f5 = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 15) == 0) f5 = 5'h1F;
            f3 = $urandom_range(0, 1) ? LW_SW : LD_SD;
            if ($urandom_range(0, 15) == 0) f3 = 3'b000;
            a = 64'h4000 + 64'($urandom_range(0, 3)) * 8;
            if (f3 == LW_SW && $urandom_range(0, 1) == 1) a = a + 4;
            if ($urandom_range(0, 11) == 0) a = a + 64'($urandom_range(1, 3));
            t = {$urandom, $urandom};
            do_op(f5, f3, a, t, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
                idle_ev($urandom_range(0, 1) == 1, 64'h4000 + 64'($urandom_range(0, 31)),
                        $urandom_range(0, 5) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
